// File: rtl/bluetooth_uart_rx_pkg.sv
// Shared types and constants for the HC-06 UART receive path.
package bt_uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

  localparam int OVERSAMPLE   = 16;
  localparam int MID_TICK     = 8;
  localparam int CLK_DIV_DFLT = 325;
  localparam int NBITS_MIN    = 5;
  localparam int NBITS_MAX    = 8;

  // Out-of-range frame lengths fall back to a full byte.
  function automatic logic [3:0] nbits_eff(input logic [3:0] n);
    if ((n >= 4'(NBITS_MIN)) && (n <= 4'(NBITS_MAX))) begin
      return n;
    end else begin
      return 4'(NBITS_MAX);
    end
  endfunction

endpackage

// File: rtl/bluetooth_uart_rx_if.sv
// Receive-side bus: serial line and control in, holding register and status out.
interface bluetooth_uart_rx_if;
  logic       RxEn;
  logic       Rx;
  logic [3:0] NBits;
  logic       RxReady;
  logic [7:0] RxData;
  logic       RxValid;
  logic       RxDone;
  logic       FrameErr;
  logic       Overrun;

  modport master (
    output RxEn, Rx, NBits, RxReady,
    input  RxData, RxValid, RxDone, FrameErr, Overrun
  );

  modport slave (
    input  RxEn, Rx, NBits, RxReady,
    output RxData, RxValid, RxDone, FrameErr, Overrun
  );
endinterface

// File: rtl/bluetooth_uart_rx_tick_gen.sv
// Free-running oversample tick generator, one-clock pulse every CLK_DIV clocks.
module bt_rx_tick_gen #(
  parameter int CLK_DIV = 325
) (
  input  logic Clk,
  input  logic Rst,
  output logic Tick
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          r_tick;

  // Divider counter and registered tick pulse.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (r_cnt == CW'(CLK_DIV - 1)) begin
      r_cnt  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + CW'(1);
      r_tick <= 1'b0;
    end
  end

  assign Tick = r_tick;
endmodule

// File: rtl/bluetooth_uart_rx.sv
// HC-06 UART receiver: 16x oversampled framing FSM feeding a one-entry holding register.
module bluetooth_uart_rx
  import bt_uart_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DFLT
) (
  input logic                Clk,
  input logic                Rst,
  bluetooth_uart_rx_if.slave bus
);

  logic       w_tick;
  logic       r_sync1, r_sync2, r_prev;
  logic       w_fall;
  rx_state_e  r_state, w_state_nxt;
  logic [3:0] r_tick_cnt, w_tick_cnt_nxt;
  logic [2:0] r_bit_cnt, w_bit_cnt_nxt;
  logic [3:0] r_nbits, w_nbits_nxt;
  logic [7:0] r_shift, w_shift_nxt;
  logic       w_good, w_ferr, w_load, w_ovr;
  logic [7:0] r_data;
  logic       r_valid, r_done, r_ferr, r_ovr;

  bt_rx_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .Clk  (Clk),
    .Rst  (Rst),
    .Tick (w_tick)
  );

  // Two-flop synchronizer plus one history flop for edge detection.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= bus.Rx;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_fall = r_prev & ~r_sync2;

  // Next-state, counters and data capture for the framing FSM.
  always_comb begin
    w_state_nxt    = r_state;
    w_tick_cnt_nxt = r_tick_cnt;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_nbits_nxt    = r_nbits;
    w_shift_nxt    = r_shift;
    w_good         = 1'b0;
    w_ferr         = 1'b0;
    if (!bus.RxEn) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_fall) begin
            w_state_nxt    = ST_START;
            w_tick_cnt_nxt = 4'd0;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_START: begin
          if (w_tick && (r_tick_cnt == 4'(MID_TICK - 1))) begin
            if (r_sync2) begin
              w_state_nxt = ST_IDLE;
            end else begin
              w_state_nxt    = ST_DATA;
              w_nbits_nxt    = nbits_eff(bus.NBits);
              w_tick_cnt_nxt = 4'd0;
              w_bit_cnt_nxt  = 3'd0;
              w_shift_nxt    = 8'h00;
            end
          end else if (w_tick) begin
            w_tick_cnt_nxt = r_tick_cnt + 4'd1;
          end else begin
            w_tick_cnt_nxt = r_tick_cnt;
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            // 4-bit counter wraps back to 0 after the 16th tick.
            w_tick_cnt_nxt = r_tick_cnt + 4'd1;
            if (r_tick_cnt == 4'(OVERSAMPLE - 1)) begin
              w_shift_nxt[r_bit_cnt] = r_sync2;
              if ({1'b0, r_bit_cnt} == (r_nbits - 4'd1)) begin
                w_state_nxt = ST_STOP;
              end else begin
                w_bit_cnt_nxt = r_bit_cnt + 3'd1;
              end
            end else begin
              w_state_nxt = ST_DATA;
            end
          end else begin
            w_tick_cnt_nxt = r_tick_cnt;
          end
        end
        ST_STOP: begin
          if (w_tick) begin
            w_tick_cnt_nxt = r_tick_cnt + 4'd1;
            if (r_tick_cnt == 4'(OVERSAMPLE - 1)) begin
              w_state_nxt = ST_IDLE;
              w_good      = r_sync2;
              w_ferr      = ~r_sync2;
            end else begin
              w_state_nxt = ST_STOP;
            end
          end else begin
            w_tick_cnt_nxt = r_tick_cnt;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // A slot being consumed in the same cycle counts as free.
  assign w_load = w_good & (~r_valid | bus.RxReady);
  assign w_ovr  = w_good & r_valid & ~bus.RxReady;

  // FSM state, counters, holding register and status pulses.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state    <= ST_IDLE;
      r_tick_cnt <= 4'd0;
      r_bit_cnt  <= 3'd0;
      r_nbits    <= 4'd8;
      r_shift    <= 8'h00;
      r_data     <= 8'h00;
      r_valid    <= 1'b0;
      r_done     <= 1'b0;
      r_ferr     <= 1'b0;
      r_ovr      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_tick_cnt <= w_tick_cnt_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_nbits    <= w_nbits_nxt;
      r_shift    <= w_shift_nxt;
      r_done     <= w_good;
      r_ferr     <= w_ferr;
      r_ovr      <= w_ovr;
      if (w_load) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (r_valid && bus.RxReady) begin
        r_valid <= 1'b0;
      end else begin
        r_valid <= r_valid;
      end
    end
  end

  assign bus.RxData   = r_data;
  assign bus.RxValid  = r_valid;
  assign bus.RxDone   = r_done;
  assign bus.FrameErr = r_ferr;
  assign bus.Overrun  = r_ovr;

endmodule

// File: tb/tb_bluetooth_uart_rx.sv
// Directed self-checking bench for bluetooth_uart_rx with a fast tick divider.
module tb_bluetooth_uart_rx;
  localparam int CLK_DIV  = 4;
  localparam int BIT_CLKS = CLK_DIV * 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bluetooth_uart_rx_if bif ();

  bluetooth_uart_rx #(.CLK_DIV(CLK_DIV)) dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bif)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_done = 0, n_ferr = 0, n_ovr = 0, n_valid = 0;
  logic [7:0] last_data = 8'h00;
  int d0, f0, o0, v0;

  // Pulse and occupancy counters sampled away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (bif.RxDone) begin
        n_done++;
        last_data <= bif.RxData;
      end
      if (bif.FrameErr) n_ferr++;
      if (bif.Overrun)  n_ovr++;
      if (bif.RxValid)  n_valid++;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    d0 = n_done; f0 = n_ferr; o0 = n_ovr; v0 = n_valid;
  endtask

  task automatic send_bits(input logic [7:0] d, input int nb);
    bif.Rx = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < nb; i++) begin
      bif.Rx = d[i];
      wait_clks(BIT_CLKS);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input int nb, input logic stop);
    send_bits(d, nb);
    bif.Rx = stop;
    wait_clks(BIT_CLKS);
    bif.Rx = 1'b1;
    wait_clks(BIT_CLKS);
  endtask

  initial begin
    bif.RxEn = 1'b1; bif.Rx = 1'b1; bif.NBits = 4'd8; bif.RxReady = 1'b0;
    wait_clks(5);
    check("reset_data",  32'(bif.RxData),   32'h00);
    check("reset_valid", 32'(bif.RxValid),  32'h0);
    check("reset_done",  32'(bif.RxDone),   32'h0);
    check("reset_ferr",  32'(bif.FrameErr), 32'h0);
    check("reset_ovr",   32'(bif.Overrun),  32'h0);
    rst = 1'b0;
    wait_clks(2 * BIT_CLKS);

    // Basic byte with consumer always ready.
    bif.RxReady = 1'b1;
    snap();
    send_frame(8'hA5, 8, 1'b1);
    check("a5_done",   32'(n_done - d0),  32'd1);
    check("a5_ferr",   32'(n_ferr - f0),  32'd0);
    check("a5_data",   32'(last_data),    32'hA5);
    check("a5_vcycles",32'(n_valid - v0), 32'd1);
    check("a5_valid",  32'(bif.RxValid),  32'h0);

    // Short start glitch, then a real frame.
    snap();
    bif.Rx = 1'b0;
    wait_clks(4 * CLK_DIV);
    bif.Rx = 1'b1;
    wait_clks(2 * BIT_CLKS);
    check("glitch_done", 32'(n_done - d0), 32'd0);
    check("glitch_ferr", 32'(n_ferr - f0), 32'd0);
    send_frame(8'h3C, 8, 1'b1);
    check("3c_done", 32'(n_done - d0), 32'd1);
    check("3c_data", 32'(last_data),   32'h3C);

    // Bad stop bit.
    snap();
    send_frame(8'hFF, 8, 1'b0);
    check("ferr_pulse",  32'(n_ferr - f0),  32'd1);
    check("ferr_done",   32'(n_done - d0),  32'd0);
    check("ferr_valid",  32'(n_valid - v0), 32'd0);

    // Overrun with consumer stalled.
    bif.RxReady = 1'b0;
    snap();
    send_frame(8'h11, 8, 1'b1);
    check("ovr_first_valid", 32'(bif.RxValid), 32'h1);
    check("ovr_first_data",  32'(bif.RxData),  32'h11);
    check("ovr_first_ovr",   32'(n_ovr - o0),  32'd0);
    send_frame(8'h22, 8, 1'b1);
    check("ovr_pulse",       32'(n_ovr - o0),  32'd1);
    check("ovr_keep_data",   32'(bif.RxData),  32'h11);
    check("ovr_keep_valid",  32'(bif.RxValid), 32'h1);
    bif.RxReady = 1'b1;
    wait_clks(1);
    check("ovr_consumed",    32'(bif.RxValid), 32'h0);

    // Frame-length variants, including an out-of-range setting.
    bif.NBits = 4'd7;
    send_frame(8'h41, 7, 1'b1);
    check("nb7_data", 32'(last_data), 32'h41);
    bif.NBits = 4'd12;
    send_frame(8'h96, 8, 1'b1);
    check("nb12_data", 32'(last_data), 32'h96);
    bif.NBits = 4'd5;
    bif.RxReady = 1'b0;
    send_frame(8'h15, 5, 1'b1);
    check("nb5_data",  32'(bif.RxData),  32'h15);
    check("nb5_valid", 32'(bif.RxValid), 32'h1);

    // Reset in the middle of a frame.
    bif.NBits = 4'd8;
    snap();
    send_bits(8'hC3, 3);
    rst = 1'b1;
    bif.Rx = 1'b1;
    wait_clks(4);
    check("rst_mid_data",  32'(bif.RxData),   32'h00);
    check("rst_mid_valid", 32'(bif.RxValid),  32'h0);
    check("rst_mid_flags", 32'({bif.RxDone, bif.FrameErr, bif.Overrun}), 32'h0);
    rst = 1'b0;
    wait_clks(10 * BIT_CLKS);
    check("rst_mid_nodone", 32'(n_done - d0), 32'd0);
    check("rst_mid_noferr", 32'(n_ferr - f0), 32'd0);
    send_frame(8'hC3, 8, 1'b1);
    check("rst_next_data",  32'(bif.RxData),  32'hC3);
    check("rst_next_valid", 32'(bif.RxValid), 32'h1);

    // Receiver disabled in the middle of a frame.
    snap();
    send_bits(8'h5A, 3);
    bif.RxEn = 1'b0;
    wait_clks(4);
    bif.Rx = 1'b1;
    wait_clks(10 * BIT_CLKS);
    bif.RxEn = 1'b1;
    wait_clks(4);
    check("en_abort_done", 32'(n_done - d0), 32'd0);
    check("en_abort_ferr", 32'(n_ferr - f0), 32'd0);
    check("en_abort_ovr",  32'(n_ovr - o0),  32'd0);
    check("en_keep_data",  32'(bif.RxData),  32'hC3);
    check("en_keep_valid", 32'(bif.RxValid), 32'h1);
    bif.RxReady = 1'b1;
    wait_clks(2);
    snap();
    send_frame(8'hC3, 8, 1'b1);
    check("en_next_done", 32'(n_done - d0), 32'd1);
    check("en_next_data", 32'(last_data),   32'hC3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
